hilo_muldiv_unit: RTL and testbench
===================================

# hilo_muldiv_unit

Parametrised HI/LO multiply/divide unit for the pipelined CPU. It replaces the single-cycle HI/LO accumulator register with an iterative engine. The engine supports signed and unsigned multiply, signed and unsigned divide, multiply-accumulate, and direct HI/LO writes. It sits beside the EX stage: EX issues one operation through a start/busy handshake, and HI/LO are read by MFHI/MFLO forwarding.

## Interface
- `WIDTH`, default 32: operand width; HI and LO are each `WIDTH` bits.
- `clk` input, 1 bit: rising-edge clock.
- `reset` input, 1 bit: synchronous, active-high.
- `start` input, 1 bit: operation request, sampled on the rising edge.
- `op` input, 3 bits: operation code; encodings are in `hilo_pkg`.
- `rs_val` input, `WIDTH` bits: operand A (multiplicand/dividend; MTHI/MTLO data).
- `rt_val` input, `WIDTH` bits: operand B (multiplier/divisor).
- `cancel` input, 1 bit: abort the in-flight operation (pipeline flush/exception).
- `busy` output, 1 bit: iteration in progress; new `start` is ignored.
- `done` output, 1 bit: one-cycle pulse in the cycle HI/LO show a new arithmetic result.
- `hi` output, `WIDTH` bits: HI register.
- `lo` output, `WIDTH` bits: LO register.

## Operation
- Op codes:
  - 0 NOP
  - 1 MULTU
  - 2 MULT
  - 3 DIVU
  - 4 DIV
  - 5 MADDU: {HI,LO} += A*B, unsigned
  - 6 MTHI
  - 7 MTLO
- Accept condition: `start && !busy && op!=NOP`. When `busy=1`, `start` is ignored; no queueing.
- MTHI/MTLO are written on the accepting edge. They do not raise `busy` or `done`. The other register is unchanged.
- MULT/DIV:
  - Operands are converted to magnitudes at accept, and result signs are latched.
  - Radix-2 iteration, one bit per cycle, `WIDTH` iterations.
  - Unsigned shift-add multiply; restoring divide.
- Sign fix-up:
  - Product sign = signA XOR signB.
  - Quotient sign = signA XOR signB.
  - Remainder sign = signA.
- MADDU: the `2*WIDTH`-bit product is added to the current {HI,LO} modulo 2^(2*WIDTH). Carry-out is discarded.
- Divide results: LO = quotient, HI = remainder.
- Divide by zero (unsigned and signed): LO = all ones, HI = A. Full latency is still taken.
- Signed overflow, A = most-negative and B = -1: LO = most-negative, HI = 0.
- FSM states:
  - IDLE: on accept, go to MUL or DIV.
  - MUL / DIV: a counter runs 0..WIDTH-1; on the last count, go to FIN.
  - FIN: apply sign fix-up or accumulate, write HI/LO, pulse `done`, return to IDLE.
- `cancel` in MUL/DIV/FIN: return to IDLE on that edge. HI/LO are unchanged, and no `done` is produced. `cancel` in IDLE has no effect. When `cancel` and `start` arrive in the same IDLE cycle, `start` is still accepted.
- `reset` has priority over everything:
  - state IDLE, counter 0
  - `hi`=0, `lo`=0
  - `busy`=0, `done`=0
- Reset mid-operation discards the operation.

## Timing
- Accept on edge N.
  - `busy`=1 after edges N..N+WIDTH, i.e. during `WIDTH+1` cycles.
  - HI/LO updated and `done`=1 after edge N+WIDTH+1; `busy`=0 in that same cycle.
- A back-to-back `start` is accepted on edge N+WIDTH+1, in the `done` cycle.
- `hi`/`lo` hold the old value throughout `busy`. They change only on edge N+WIDTH+1 (arithmetic) or edge N (MTHI/MTLO).
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- `hilo_pkg` holds:
  - the op-code localparams and `op_t` typedef
  - FSM state encoding `state_t` (IDLE, MUL, DIV, FIN)
- The sub-module `hilo_iter_core` is natural. It holds the shift-add/restoring-subtract datapath with `WIDTH`-bit magnitude inputs and `2*WIDTH`-bit product / quotient+remainder outputs. The top level keeps the FSM, sign handling, accumulate and the HI/LO registers.

## Test plan
All scenarios use `WIDTH`=32.
1. MULTU 0xFFFFFFFF × 0xFFFFFFFF -> after 33 cycles `done` pulses; HI=0xFFFFFFFE, LO=0x00000001; `busy` high for exactly 33 cycles.
2. MULT -3 × 5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1. DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
3. DIVU 100 / 0 -> LO=0xFFFFFFFF, HI=100. DIV 0x80000000 / -1 -> LO=0x80000000, HI=0.
4. MTHI 0, MTLO 0xFFFFFFFF, then MADDU 1 × 1 -> HI=0x00000001, LO=0x00000000. A `start` issued mid-busy is ignored, with HI/LO checked unchanged.
5. Start DIVU; assert `cancel` at iteration 10 -> `busy` drops next cycle, no `done`, HI/LO keep their prior values. A new MULTU in the same cycle as a later `cancel` is accepted.
6. Assert `reset` mid-MULT -> next cycle `hi`=`lo`=0, `busy`=`done`=0. The FSM accepts a new op on the following cycle.

Source files
------------

// File: rtl/hilo_pkg.sv
// hilo_pkg: op-code and FSM state encodings shared by the HI/LO multiply/divide unit
package hilo_pkg;
    typedef logic [2:0] op_t;
    localparam op_t OP_NOP   = 3'd0;
    localparam op_t OP_MULTU = 3'd1;
    localparam op_t OP_MULT  = 3'd2;
    localparam op_t OP_DIVU  = 3'd3;
    localparam op_t OP_DIV   = 3'd4;
    localparam op_t OP_MADDU = 3'd5;
    localparam op_t OP_MTHI  = 3'd6;
    localparam op_t OP_MTLO  = 3'd7;
    typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;
endpackage

// File: rtl/hilo_iter_core.sv
// hilo_iter_core: radix-2 shift-add multiply / restoring divide datapath on magnitudes
module hilo_iter_core #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               step,
    input  logic               isDiv,
    input  logic [WIDTH-1:0]   aMag,
    input  logic [WIDTH-1:0]   bMag,
    output logic [2*WIDTH-1:0] result
);
    logic [WIDTH-1:0] hiAcc, loAcc, operandB;
    logic [WIDTH:0]   addSum, shifted, diff;
    always_comb begin
        addSum  = {1'b0, hiAcc} + (loAcc[0] ? {1'b0, operandB} : '0);
        shifted = {hiAcc, loAcc[WIDTH-1]};
        diff    = shifted - {1'b0, operandB};
    end
    // Multiply keeps the multiplier in loAcc; divide shifts quotient bits into it.
    always_ff @(posedge clk) begin
        if (reset) begin
            hiAcc    <= '0;
            loAcc    <= '0;
            operandB <= '0;
        end else if (load) begin
            hiAcc    <= '0;
            loAcc    <= aMag;
            operandB <= bMag;
        end else if (step) begin
            if (isDiv) begin
                hiAcc <= diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
                loAcc <= {loAcc[WIDTH-2:0], ~diff[WIDTH]};
            end else begin
                {hiAcc, loAcc} <= {addSum, loAcc[WIDTH-1:1]};
            end
        end
    end
    assign result = {hiAcc, loAcc};
endmodule

// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: iterative HI/LO multiply/divide/accumulate engine with start/busy handshake
import hilo_pkg::*;
module hilo_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    state_t             state;
    logic [CW-1:0]      cnt;
    logic               signQ, signR, divZero, divOp, isMaddu;
    logic [WIDTH-1:0]   aRaw;
    logic               accept, isSigned, signA, signB, opDiv;
    logic [WIDTH-1:0]   aMag, bMag, quotFix, remFix;
    logic [2*WIDTH-1:0] coreRes, prodFix, divResult, finResult;
    always_comb begin
        accept    = start && !busy && op != OP_NOP;
        isSigned  = op == OP_MULT || op == OP_DIV;
        opDiv     = op == OP_DIVU || op == OP_DIV;
        signA     = isSigned && rs_val[WIDTH-1];
        signB     = isSigned && rt_val[WIDTH-1];
        aMag      = signA ? -rs_val : rs_val;
        bMag      = signB ? -rt_val : rt_val;
        prodFix   = signQ ? -coreRes : coreRes;
        quotFix   = signQ ? -coreRes[WIDTH-1:0] : coreRes[WIDTH-1:0];
        remFix    = signR ? -coreRes[2*WIDTH-1:WIDTH] : coreRes[2*WIDTH-1:WIDTH];
        divResult = divZero ? {aRaw, {WIDTH{1'b1}}} : {remFix, quotFix};
        finResult = isMaddu ? {hi, lo} + coreRes : divOp ? divResult : prodFix;
    end
    hilo_iter_core #(.WIDTH(WIDTH)) core (
        .clk    (clk),
        .reset  (reset),
        .load   (state == IDLE && accept),
        .step   (state == MUL || state == DIV),
        .isDiv  (state == DIV),
        .aMag   (aMag),
        .bMag   (bMag),
        .result (coreRes)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            hi      <= '0;
            lo      <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            signQ   <= 1'b0;
            signR   <= 1'b0;
            divZero <= 1'b0;
            divOp   <= 1'b0;
            isMaddu <= 1'b0;
            aRaw    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    if (op == OP_MTHI) hi <= rs_val;
                    else if (op == OP_MTLO) lo <= rs_val;
                    else begin
                        state   <= opDiv ? DIV : MUL;
                        busy    <= 1'b1;
                        cnt     <= '0;
                        signQ   <= signA ^ signB;
                        signR   <= signA;
                        divZero <= opDiv && rt_val == '0;
                        divOp   <= opDiv;
                        isMaddu <= op == OP_MADDU;
                        aRaw    <= rs_val;
                    end
                end
                MUL, DIV: begin
                    cnt <= cnt + 1'b1;
                    if (cancel) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (cnt == LAST) state <= FIN;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    if (!cancel) begin
                        {hi, lo} <= finResult;
                        done     <= 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb_hilo_muldiv_unit: directed self-checking bench for the HI/LO multiply/divide unit
module tb_hilo_muldiv_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] rsVal = '0;
    logic [31:0] rtVal = '0;
    logic        cancel = 1'b0;
    logic        busy, done;
    logic [31:0] hi, lo;
    int          total = 0;
    int          bad = 0;
    int          nb;
    int          doneSeen;
    hilo_muldiv_unit #(.WIDTH(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .rs_val (rsVal),
        .rt_val (rtVal),
        .cancel (cancel),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    // Presents one start cycle; returns at the negedge just after the accepting edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        rsVal = a;
        rtVal = b;
        @(negedge clk);
        start = 1'b0;
    endtask
    task automatic waitDone(output int n);
        n = 0;
        for (int i = 0; i < 100 && done !== 1'b1; i++) begin
            if (busy) n++;
            @(negedge clk);
        end
        chk("doneSeen", {63'd0, done}, 64'd1);
        chk("busyLowAtDone", {63'd0, busy}, 64'd0);
    endtask
    task automatic runOp(input string tag, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] expHi, input logic [31:0] expLo);
        issue(o, a, b);
        waitDone(nb);
        chk({tag, "_busyCycles"}, 64'(nb), 64'd33);
        chk({tag, "_hilo"}, {hi, lo}, {expHi, expLo});
    endtask
    initial begin
        repeat (2) @(negedge clk);
        chk("rst_hi", {32'd0, hi}, 64'd0);
        chk("rst_lo", {32'd0, lo}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        reset = 1'b0;
        runOp("multuMax", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        @(negedge clk);
        chk("donePulseOnce", {63'd0, done}, 64'd0);
        runOp("multNeg", 3'd2, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1);
        runOp("multNegB", 3'd2, 32'd7, 32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFD6);
        runOp("divNegA", 3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        runOp("divNegB", 3'd4, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
        runOp("divu", 3'd3, 32'd100, 32'd7, 32'd2, 32'd14);
        runOp("divuZero", 3'd3, 32'd100, 32'd0, 32'd100, 32'hFFFFFFFF);
        runOp("divZeroNeg", 3'd4, 32'hFFFFFFF8, 32'd0, 32'hFFFFFFF8, 32'hFFFFFFFF);
        runOp("divOvf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000);
        issue(3'd6, 32'h12345678, 32'd0);
        chk("mthi", {hi, lo}, {32'h12345678, 32'h80000000});
        chk("mthiNoBusy", {62'd0, busy, done}, 64'd0);
        issue(3'd6, 32'd0, 32'd0);
        issue(3'd7, 32'hFFFFFFFF, 32'd0);
        chk("mtlo", {hi, lo}, {32'd0, 32'hFFFFFFFF});
        chk("mtloNoBusy", {62'd0, busy, done}, 64'd0);
        issue(3'd5, 32'd1, 32'd1);
        repeat (5) @(negedge clk);
        start = 1'b1;
        op    = 3'd1;
        rsVal = 32'd3;
        rtVal = 32'd3;
        @(negedge clk);
        start = 1'b0;
        chk("midBusyStillBusy", {63'd0, busy}, 64'd1);
        chk("midBusyHold", {hi, lo}, {32'd0, 32'hFFFFFFFF});
        waitDone(nb);
        chk("madduCarry", {hi, lo}, {32'd1, 32'd0});
        @(negedge clk);
        chk("ignoredStartIdle", {63'd0, busy}, 64'd0);
        issue(3'd6, 32'hFFFFFFFF, 32'd0);
        issue(3'd7, 32'hFFFFFFFF, 32'd0);
        runOp("madduWrap", 3'd5, 32'd1, 32'd1, 32'd0, 32'd0);
        issue(3'd6, 32'hAAAA5555, 32'd0);
        issue(3'd7, 32'h13572468, 32'd0);
        issue(3'd3, 32'd1000, 32'd3);
        repeat (10) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        chk("cancelBusy", {62'd0, busy, done}, 64'd0);
        doneSeen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) doneSeen++;
            @(negedge clk);
        end
        chk("cancelNoDone", 64'(doneSeen), 64'd0);
        chk("cancelHold", {hi, lo}, {32'hAAAA5555, 32'h13572468});
        @(negedge clk);
        start  = 1'b1;
        cancel = 1'b1;
        op     = 3'd1;
        rsVal  = 32'd6;
        rtVal  = 32'd7;
        @(negedge clk);
        start  = 1'b0;
        cancel = 1'b0;
        chk("startWithCancel", {63'd0, busy}, 64'd1);
        waitDone(nb);
        chk("startWithCancelRes", {hi, lo}, {32'd0, 32'd42});
        issue(3'd2, 32'hFFFFFFFD, 32'd5);
        repeat (8) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midReset", {hi, lo}, 64'd0);
        chk("midResetFlags", {62'd0, busy, done}, 64'd0);
        reset = 1'b0;
        start = 1'b1;
        op    = 3'd1;
        rsVal = 32'd2;
        rtVal = 32'd3;
        @(negedge clk);
        start = 1'b0;
        chk("postResetAccept", {63'd0, busy}, 64'd1);
        waitDone(nb);
        chk("postResetRes", {hi, lo}, {32'd0, 32'd6});
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
